// File: rtl/audio_pkg.sv
// Shared audio definitions: native sample width, I2S slot length and the
// bundle of synchronised I2S pins.
package audio_pkg;

   localparam int AUDIO_DATA_W  = 24;
   localparam int I2S_SLOT_BITS = 128;

   typedef struct packed {
      logic lrck;
      logic bck;
      logic data;
   } i2s_bus_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser for a bus of independent asynchronous
// bits. Every bit goes through the same number of stages, so bits that
// change together keep their relative alignment.
module sync_ff #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_stage [STAGES];

   // Shift the asynchronous inputs through the synchroniser chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < STAGES; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// Philips-format I2S receiver. Oversamples BCK/LRCK/DATA in the clk domain,
// assembles MSB-first words on BCK rising edges and presents one left/right
// pair per frame with a single-cycle valid strobe. Short slots and right
// words without a preceding left word are dropped and flagged.
module i2s_rx
   import audio_pkg::*;
#(
   parameter int DATA_W      = AUDIO_DATA_W,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i2s_lrck,
   input  logic              i2s_bck,
   input  logic              i2s_data,
   output logic              sample_valid,
   output logic [DATA_W-1:0] left_data,
   output logic [DATA_W-1:0] right_data,
   output logic              frame_err
);

   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] C_CNT_WORD = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

   // Bit counter that sticks at all-ones so oversized slots never wrap.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == C_CNT_MAX) ? v : v + 1'b1;
   endfunction

   i2s_bus_t          w_sync;
   logic              w_rise;
   logic              w_bound;

   logic              r_bck_d;
   logic              r_lrck_prev;
   logic              r_locked;
   logic              r_left_ok;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [DATA_W-2:0] r_shift;
   logic [DATA_W-1:0] r_left_hold;
   logic [DATA_W-1:0] r_left_data;
   logic [DATA_W-1:0] r_right_data;
   logic              r_sample_valid;
   logic              r_frame_err;

   sync_ff #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (3)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d ({i2s_lrck, i2s_bck, i2s_data}),
      .o_q (w_sync)
   );

   assign w_rise  = w_sync.bck & ~r_bck_d;
   assign w_bound = (w_sync.lrck != r_lrck_prev);

   // Delayed copy of synchronised BCK for rising-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bck_d <= 1'b0;
      end else begin
         r_bck_d <= w_sync.bck;
      end
   end

   // Slot tracking, word assembly and left/right pairing on each BCK rise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lrck_prev    <= 1'b0;
         r_locked       <= 1'b0;
         r_left_ok      <= 1'b0;
         r_bit_cnt      <= '0;
         r_shift        <= '0;
         r_left_hold    <= '0;
         r_left_data    <= '0;
         r_right_data   <= '0;
         r_sample_valid <= 1'b0;
         r_frame_err    <= 1'b0;
      end else begin
         r_sample_valid <= 1'b0;
         r_frame_err    <= 1'b0;
         if (w_rise) begin
            if (w_bound) begin
               // The bit at an LRCK change is the I2S one-bit delay slot.
               r_lrck_prev <= w_sync.lrck;
               r_bit_cnt   <= '0;
               r_locked    <= 1'b1;
               if (r_locked && (r_bit_cnt < C_CNT_WORD)) begin
                  r_frame_err <= 1'b1;
                  r_left_ok   <= 1'b0;
               end
            end else if (r_locked) begin
               if (r_bit_cnt < C_CNT_WORD) begin
                  r_shift <= {r_shift[DATA_W-3:0], w_sync.data};
               end
               r_bit_cnt <= sat_inc(r_bit_cnt);
               if (r_bit_cnt == C_CNT_LAST) begin
                  if (!w_sync.lrck) begin
                     r_left_hold <= {r_shift, w_sync.data};
                     r_left_ok   <= 1'b1;
                  end else if (r_left_ok) begin
                     r_left_data    <= r_left_hold;
                     r_right_data   <= {r_shift, w_sync.data};
                     r_sample_valid <= 1'b1;
                     r_left_ok      <= 1'b0;
                  end else begin
                     // Right word with no left partner: drop it.
                     r_frame_err <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign sample_valid = r_sample_valid;
   assign frame_err    = r_frame_err;
   assign left_data    = r_left_data;
   assign right_data   = r_right_data;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives an I2S stream in a linear sequence of
// steps and checks every output pulse (kind, data, exact cycle) against a
// scoreboard of expected events queued while the stream is generated.
module tb_i2s_rx;
   import audio_pkg::*;

   localparam int DATA_W      = AUDIO_DATA_W;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_W       = 8;

   localparam logic [1:0] K_NONE  = 2'b00;
   localparam logic [1:0] K_VALID = 2'b10;
   localparam logic [1:0] K_ERR   = 2'b01;

   typedef struct {
      logic [1:0]        kind;
      logic [DATA_W-1:0] l;
      logic [DATA_W-1:0] r;
      int                cyc;
   } ev_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              i2s_lrck;
   logic              i2s_bck;
   logic              i2s_data;
   logic              sample_valid;
   logic              frame_err;
   logic [DATA_W-1:0] left_data;
   logic [DATA_W-1:0] right_data;

   ev_t               sb[$];
   ev_t               mon_e;
   int                cyc    = 0;
   int                errors = 0;
   int                checks = 0;
   logic [DATA_W-1:0] hold_l = '0;
   logic [DATA_W-1:0] hold_r = '0;
   logic [DATA_W-1:0] tx_l;
   logic [DATA_W-1:0] tx_r;

   i2s_rx #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i2s_lrck     (i2s_lrck),
      .i2s_bck      (i2s_bck),
      .i2s_data     (i2s_data),
      .sample_valid (sample_valid),
      .left_data    (left_data),
      .right_data   (right_data),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Expected pulse appears SYNC_STAGES edges after the edge that registers
   // this BCK high; the registering edge is the next posedge.
   task automatic push_ev(input logic [1:0] k, input logic [DATA_W-1:0] l,
                          input logic [DATA_W-1:0] r);
      ev_t e;
      e.kind = k;
      e.l    = l;
      e.r    = r;
      e.cyc  = cyc + 1 + SYNC_STAGES;
      sb.push_back(e);
   endtask

   // One BCK period, starting and ending on a clk negedge.
   task automatic send_bit(input logic l, input logic d, input int half,
                           input logic [1:0] k, input logic [DATA_W-1:0] el,
                           input logic [DATA_W-1:0] er);
      i2s_bck  = 1'b0;
      i2s_lrck = l;
      i2s_data = d;
      repeat (half) @(negedge clk);
      i2s_bck = 1'b1;
      if (k != K_NONE) push_ev(k, el, er);
      repeat (half) @(negedge clk);
   endtask

   task automatic do_reset();
      i2s_bck = 1'b0;
      @(negedge clk);
      rst    = 1'b1;
      hold_l = '0;
      hold_r = '0;
      #1;
      chk("rst_mid_valid", 32'(sample_valid), 32'd0);
      chk("rst_mid_err",   32'(frame_err),    32'd0);
      chk("rst_mid_left",  32'(left_data),    32'd0);
      chk("rst_mid_right", 32'(right_data),   32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // One LRCK slot: delay bit, MSB-first word, random padding.
   task automatic send_slot(input logic l, input logic [DATA_W-1:0] w, input int nbits,
                            input int half, input logic [1:0] lsb_k, input logic start_err,
                            input logic [DATA_W-1:0] el, input logic [DATA_W-1:0] er,
                            input int rst_at);
      for (int k = 0; k < nbits; k++) begin
         logic       d;
         logic [1:0] ek;
         if (k == rst_at) do_reset();
         d  = (k >= 1 && k <= DATA_W) ? w[DATA_W-k] : 1'($urandom);
         ek = K_NONE;
         if (k == 0 && start_err) ek = K_ERR;
         if (k == DATA_W) ek = lsb_k;
         send_bit(l, d, half, ek, el, er);
      end
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                             input int half, input int nbits, input logic [1:0] k_r);
      send_slot(1'b0, l, nbits, half, K_NONE, 1'b0, l, r, -1);
      send_slot(1'b1, r, nbits, half, k_r,    1'b0, l, r, -1);
   endtask

   // Compare every output pulse with the scoreboard; outputs must hold otherwise
   always @(negedge clk) begin
      if (!rst) begin
         if (sample_valid || frame_err) begin
            chk("pulse_overlap", 32'(sample_valid & frame_err), 32'd0);
            chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               chk("pulse_kind", 32'({sample_valid, frame_err}), 32'(mon_e.kind));
               chk("pulse_latency", 32'(cyc), 32'(mon_e.cyc));
               if (mon_e.kind == K_VALID) begin
                  chk("left_data",  32'(left_data),  32'(mon_e.l));
                  chk("right_data", 32'(right_data), 32'(mon_e.r));
                  hold_l = mon_e.l;
                  hold_r = mon_e.r;
               end
            end
         end else begin
            chk("hold_left",  32'(left_data),  32'(hold_l));
            chk("hold_right", 32'(right_data), 32'(hold_r));
         end
      end
   end

   initial begin
      rst      = 1'b1;
      i2s_lrck = 1'b0;
      i2s_bck  = 1'b0;
      i2s_data = 1'b0;
      #1;
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_err",   32'(frame_err),    32'd0);
      chk("rst_left",  32'(left_data),    32'd0);
      chk("rst_right", 32'(right_data),   32'd0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Nominal: first right word is an orphan, then three good pairs
      send_frame(24'h123456, 24'hABCDEF, 4, 32, K_ERR);
      for (int n = 0; n < 3; n++) send_frame(24'h123456, 24'hABCDEF, 4, 32, K_VALID);

      // Sign extremes
      send_frame(24'h800000, 24'h7FFFFF, 4, 32, K_VALID);
      send_frame(24'hFFFFFF, 24'h000001, 4, 32, K_VALID);

      // Short left slot: error at the boundary, then orphan right word
      send_slot(1'b0, 24'h5A5A5A, 20, 4, K_NONE, 1'b0, '0, '0, -1);
      send_slot(1'b1, 24'hC3C3C3, 32, 4, K_ERR,  1'b1, '0, '0, -1);
      send_frame(24'h654321, 24'h0F0F0F, 4, 32, K_VALID);

      // Long slots at BCK=clk/4
      send_frame(24'h111111, 24'hEEEEEE, 2, I2S_SLOT_BITS, K_VALID);
      send_frame(24'h7ABCDE, 24'h812345, 2, I2S_SLOT_BITS, K_VALID);

      // Reset in the middle of a left word: relock, orphan, then a good pair
      send_slot(1'b0, 24'h222222, 32, 4, K_NONE, 1'b0, '0, '0, 10);
      send_slot(1'b1, 24'h333333, 32, 4, K_ERR,  1'b0, '0, '0, -1);
      send_frame(24'h444444, 24'h555555, 4, 32, K_VALID);

      // Loopback: transmitter outputs the ramp sample loaded one frame earlier
      tx_l = '0;
      tx_r = '0;
      for (int n = 1; n <= 4; n++) begin
         send_frame(tx_l, tx_r, 4, 32, K_VALID);
         tx_l = 24'(n * 24'h010203);
         tx_r = ~tx_l;
      end

      // Close the last right slot and let any pulse drain
      send_slot(1'b0, '0, 2, 4, K_NONE, 1'b0, '0, '0, -1);
      repeat (20) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
